// File: rtl/output_mems.sv
// Result buffer for the matrix-multiply accelerator: collects C from the compute core,
// then streams it row-major as an AXI-Stream master with TLAST on the final element.
module output_mems #(
    parameter  int OUTW        = 24,
    parameter  int M           = 7,
    parameter  int N           = 9,
    localparam int C_ADDR_BITS = $clog2(M*N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   C_wr_en,
    input  logic [C_ADDR_BITS-1:0] C_wr_addr,
    input  logic [OUTW-1:0]        C_wr_data,
    input  logic                   compute_finished,
    output logic                   buffer_free,
    output logic [OUTW-1:0]        AXIS_TDATA,
    output logic                   AXIS_TVALID,
    input  logic                   AXIS_TREADY,
    output logic                   AXIS_TLAST
);

    localparam int DEPTH = M * N;
    localparam logic [C_ADDR_BITS-1:0] LAST_ADDR = C_ADDR_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        PREFETCH = 2'd1,
        STREAM   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OUTW-1:0]        mem [DEPTH];

    // Two-entry holding stage; the synchronous memory read lands directly in it,
    // so the head entry is the registered AXI-Stream output.
    logic [OUTW-1:0]        hold_data [2];
    logic                   hold_last [2];
    logic                   head;
    logic                   tail;
    logic [1:0]             count;

    logic [C_ADDR_BITS-1:0] rd_cnt;
    logic                   issued_all;

    logic                   pop;
    logic                   issue;
    logic                   last_hs;
    logic                   wr_ok;

    assign AXIS_TVALID = (count != 2'd0);
    assign AXIS_TDATA  = hold_data[head];
    assign AXIS_TLAST  = AXIS_TVALID && hold_last[head];
    assign buffer_free = (state_q == COLLECT);

    assign pop     = AXIS_TVALID && AXIS_TREADY;
    assign last_hs = pop && hold_last[head];
    assign wr_ok   = (state_q == COLLECT) && C_wr_en && (int'(C_wr_addr) < DEPTH);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (compute_finished) begin
                    state_d = PREFETCH;
                end
            end
            PREFETCH: begin
                issue   = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                issue = !issued_all && ((count < 2'd2) || pop);
                if (last_hs) begin
                    issue   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[C_wr_addr] <= C_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            rd_cnt       <= '0;
            issued_all   <= 1'b0;
            hold_data[0] <= '0;
            hold_data[1] <= '0;
            hold_last[0] <= 1'b0;
            hold_last[1] <= 1'b0;
        end else if (last_hs) begin
            count      <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            rd_cnt     <= '0;
            issued_all <= 1'b0;
        end else begin
            if (issue) begin
                hold_data[tail] <= mem[rd_cnt];
                hold_last[tail] <= (rd_cnt == LAST_ADDR);
                tail            <= ~tail;
                // Counter parks on the final address instead of wrapping.
                if (rd_cnt == LAST_ADDR) begin
                    issued_all <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, issue} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_output_mems.sv
// Directed bench for output_mems: load C, drain it under several ready patterns,
// and check ordering, TLAST, latency, stalls, ignored inputs and reset abort.
module tb_output_mems;

    localparam int OUTW  = 24;
    localparam int M     = 7;
    localparam int N     = 9;
    localparam int DEPTH = M * N;
    localparam int AW    = $clog2(DEPTH);

    logic            clk;
    logic            reset;
    logic            C_wr_en;
    logic [AW-1:0]   C_wr_addr;
    logic [OUTW-1:0] C_wr_data;
    logic            compute_finished;
    logic            buffer_free;
    logic [OUTW-1:0] AXIS_TDATA;
    logic            AXIS_TVALID;
    logic            AXIS_TREADY;
    logic            AXIS_TLAST;

    int exp_mem [DEPTH];
    int total;
    int passed;

    output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .C_wr_en          (C_wr_en),
        .C_wr_addr        (C_wr_addr),
        .C_wr_data        (C_wr_data),
        .compute_finished (compute_finished),
        .buffer_free      (buffer_free),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TREADY      (AXIS_TREADY),
        .AXIS_TLAST       (AXIS_TLAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input int addr, input int data);
        @(negedge clk);
        C_wr_en   = 1'b1;
        C_wr_addr = AW'(addr);
        C_wr_data = OUTW'(data);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, i * 3 - 50);
            exp_mem[i] = i * 3 - 50;
        end
        @(negedge clk);
        C_wr_en = 1'b0;
    endtask

    // Pulse compute_finished (optionally with a same-cycle write) and check the PREFETCH cycle.
    task automatic pulse_finish(input bit with_write, input int addr, input int data);
        @(negedge clk);
        compute_finished = 1'b1;
        C_wr_en          = with_write;
        C_wr_addr        = AW'(addr);
        C_wr_data        = OUTW'(data);
        @(negedge clk);
        compute_finished = 1'b0;
        C_wr_en          = 1'b0;
        total++;
        if (buffer_free !== 1'b0) $display("FAIL busy_after_finish buffer_free=%b want 0", buffer_free);
        else passed++;
        total++;
        if (AXIS_TVALID !== 1'b0) $display("FAIL valid_at_t1 tvalid=%b want 0", AXIS_TVALID);
        else passed++;
    endtask

    // mode 0: ready always high; mode 1: random ready.
    task automatic drain(input int mode, input int stop_beats, input bit inject);
        int          beats;
        int          cycles;
        bit          r;
        bit          stalled;
        logic [OUTW-1:0] prev_data;
        logic        prev_last;
        logic [OUTW-1:0] want;
        beats   = 0;
        cycles  = 0;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (beats < stop_beats && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (mode == 0) begin
                total++;
                if (AXIS_TVALID !== 1'b1) $display("FAIL contiguous beat=%0d tvalid=%b want 1", beats, AXIS_TVALID);
                else passed++;
            end
            if (stalled) begin
                total++;
                if (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== prev_data || AXIS_TLAST !== prev_last)
                    $display("FAIL stall_stable beat=%0d got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             beats, AXIS_TVALID, $signed(AXIS_TDATA), AXIS_TLAST, $signed(prev_data), prev_last);
                else passed++;
            end
            if (inject && cycles == 4) begin
                C_wr_en          = 1'b1;
                C_wr_addr        = AW'(5);
                C_wr_data        = OUTW'(999);
                compute_finished = 1'b1;
            end else begin
                C_wr_en          = 1'b0;
                compute_finished = 1'b0;
            end
            r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            AXIS_TREADY = r;
            if (AXIS_TVALID === 1'b1 && r) begin
                want = OUTW'(exp_mem[beats]);
                total++;
                if (AXIS_TDATA !== want)
                    $display("FAIL beat_data beat=%0d got=%0d want=%0d", beats, $signed(AXIS_TDATA), $signed(want));
                else passed++;
                total++;
                if (AXIS_TLAST !== (beats == DEPTH - 1))
                    $display("FAIL beat_last beat=%0d got=%b want=%b", beats, AXIS_TLAST, beats == DEPTH - 1);
                else passed++;
                beats++;
            end
            stalled   = (AXIS_TVALID === 1'b1) && !r;
            prev_data = AXIS_TDATA;
            prev_last = AXIS_TLAST;
        end
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
        total++;
        if (beats != stop_beats) $display("FAIL drain_timeout beats=%0d want %0d", beats, stop_beats);
        else passed++;
        if (stop_beats == DEPTH) begin
            @(negedge clk);
            AXIS_TREADY = 1'b0;
            total++;
            if (AXIS_TVALID !== 1'b0 || buffer_free !== 1'b1)
                $display("FAIL after_last tvalid=%b free=%b want tvalid=0 free=1", AXIS_TVALID, buffer_free);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (buffer_free !== 1'b1 || AXIS_TVALID !== 1'b0 || AXIS_TLAST !== 1'b0 || AXIS_TDATA !== '0)
            $display("FAIL reset_state free=%b v=%b l=%b d=%0d want 1 0 0 0",
                     buffer_free, AXIS_TVALID, AXIS_TLAST, AXIS_TDATA);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_stream_full();
        load_ramp();
        pulse_finish(1'b0, 0, 0);
        drain(0, DEPTH, 1'b0);
    endtask

    task automatic test_random_ready();
        pulse_finish(1'b0, 0, 0);
        drain(1, DEPTH, 1'b0);
    endtask

    task automatic test_last_write_with_finish();
        exp_mem[DEPTH - 1] = -1;
        pulse_finish(1'b1, DEPTH - 1, -1);
        drain(0, DEPTH, 1'b0);
    endtask

    task automatic test_ignore_during_drain();
        pulse_finish(1'b0, 0, 0);
        drain(0, DEPTH, 1'b1);
        // A late compute_finished must not have restarted a drain.
        @(negedge clk);
        total++;
        if (AXIS_TVALID !== 1'b0 || buffer_free !== 1'b1)
            $display("FAIL no_restart tvalid=%b free=%b want 0 1", AXIS_TVALID, buffer_free);
        else passed++;
    endtask

    task automatic test_bad_addr();
        write_word(63, 555);
        write_word(127, 777);
        @(negedge clk);
        C_wr_en = 1'b0;
        pulse_finish(1'b0, 0, 0);
        drain(1, DEPTH, 1'b0);
    endtask

    task automatic test_reset_abort();
        pulse_finish(1'b0, 0, 0);
        drain(0, 21, 1'b0);
        @(negedge clk);
        AXIS_TREADY = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (AXIS_TVALID !== 1'b0 || buffer_free !== 1'b1 || AXIS_TLAST !== 1'b0)
            $display("FAIL abort tvalid=%b free=%b last=%b want 0 1 0", AXIS_TVALID, buffer_free, AXIS_TLAST);
        else passed++;
        pulse_finish(1'b0, 0, 0);
        drain(0, DEPTH, 1'b0);
    endtask

    initial begin
        total            = 0;
        passed           = 0;
        reset            = 1'b1;
        C_wr_en          = 1'b0;
        C_wr_addr        = '0;
        C_wr_data        = '0;
        compute_finished = 1'b0;
        AXIS_TREADY      = 1'b0;
        test_reset();
        test_stream_full();
        test_random_ready();
        test_last_write_with_finish();
        test_ignore_during_drain();
        test_bad_addr();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
